// File: rtl/spi_readout_responder.sv
// AstroPix-style SPI readout responder: queues 64-bit hit words and returns them two bits per SPI clock on MISO0/MISO1.
// All SPI inputs are oversampled in the system clock domain; MOSI bytes are collected alongside the transmit path.
module spi_readout_responder #(
  parameter int HIT_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        spi_csb,
  input  logic        spi_clock,
  input  logic        spi_mosi,
  output logic        spi_miso0,
  output logic        spi_miso1,
  output logic        interruptB,
  input  logic [63:0] hit_data,
  input  logic        hit_valid,
  output logic        hit_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic [15:0] words_sent,
  output logic        word_aborted
);

  localparam int PW = (HIT_DEPTH > 1) ? $clog2(HIT_DEPTH) : 1;
  localparam int CW = PW + 1;

  // [0] first flop, [1] synchronized value, [2] previous synchronized value
  logic [2:0] csb_sr, clk_sr, mosi_sr;

  logic [63:0]   mem [HIT_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic [63:0] shifter;
  logic [4:0]  pair_cnt;
  logic        tx_real;
  logic [7:0]  rx_shift;
  logic [2:0]  bit_cnt;

  logic        csb_low, clk_rise, clk_fall, csb_rise;
  logic        push, pop;
  logic [63:0] tx_word;
  logic [7:0]  rx_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      csb_sr  <= 3'b111;
      clk_sr  <= 3'b000;
      mosi_sr <= 3'b000;
    end else begin
      csb_sr  <= {csb_sr[1:0], spi_csb};
      clk_sr  <= {clk_sr[1:0], spi_clock};
      mosi_sr <= {mosi_sr[1:0], spi_mosi};
    end
  end

  always_comb begin
    csb_low   = ~csb_sr[1];
    clk_rise  = csb_low & clk_sr[1] & ~clk_sr[2];
    clk_fall  = csb_low & ~clk_sr[1] & clk_sr[2];
    csb_rise  = csb_sr[1] & ~csb_sr[2];
    hit_ready = (count < CW'(HIT_DEPTH));
    push      = hit_valid & hit_ready;
    pop       = clk_rise & (pair_cnt == 5'd0) & (count != '0);
    tx_word   = pop ? mem[rd_ptr] : 64'd0;
    // MOSI taken from the stage aligned with the last high SPI clock sample
    rx_next   = {rx_shift[6:0], mosi_sr[2]};
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= hit_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shifter      <= '0;
      pair_cnt     <= '0;
      tx_real      <= 1'b0;
      spi_miso0    <= 1'b0;
      spi_miso1    <= 1'b0;
      words_sent   <= '0;
      word_aborted <= 1'b0;
      rx_shift     <= '0;
      bit_cnt      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      interruptB   <= 1'b1;
    end else begin
      rx_valid   <= 1'b0;
      interruptB <= ~((count != '0) | tx_real);
      if (csb_rise) begin
        pair_cnt  <= '0;
        bit_cnt   <= '0;
        rx_shift  <= '0;
        spi_miso0 <= 1'b0;
        spi_miso1 <= 1'b0;
        if (tx_real) begin
          word_aborted <= 1'b1;
          tx_real      <= 1'b0;
        end
      end else if (!csb_low) begin
        spi_miso0 <= 1'b0;
        spi_miso1 <= 1'b0;
      end else begin
        if (clk_rise) begin
          pair_cnt <= pair_cnt + 1'b1;
          if (pair_cnt == 5'd0) begin
            tx_real   <= pop;
            spi_miso0 <= tx_word[63];
            spi_miso1 <= tx_word[62];
            shifter   <= {tx_word[61:0], 2'b00};
          end else begin
            spi_miso0 <= shifter[63];
            spi_miso1 <= shifter[62];
            shifter   <= {shifter[61:0], 2'b00};
          end
        end
        if (clk_fall) begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
            rx_data  <= rx_next;
            rx_valid <= 1'b1;
          end
          // Counter has wrapped to 0 only after the 32nd rising edge of a word
          if (pair_cnt == 5'd0 && tx_real) begin
            words_sent <= words_sent + 1'b1;
            tx_real    <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_readout_responder.sv
// Directed bench for spi_readout_responder acting as the SPI controller side.
// SPI half-period is 8 system clocks; DUT outputs are sampled on the falling system clock edge.
module tb_spi_readout_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        spi_csb, spi_clock, spi_mosi;
  logic        spi_miso0, spi_miso1, interruptB;
  logic [63:0] hit_data;
  logic        hit_valid, hit_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] words_sent;
  logic        word_aborted;

  int total = 0;
  int bad   = 0;

  logic [7:0] rx_q[$];

  spi_readout_responder #(.HIT_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .spi_csb(spi_csb), .spi_clock(spi_clock), .spi_mosi(spi_mosi),
    .spi_miso0(spi_miso0), .spi_miso1(spi_miso1), .interruptB(interruptB),
    .hit_data(hit_data), .hit_valid(hit_valid), .hit_ready(hit_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .words_sent(words_sent), .word_aborted(word_aborted)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rx_valid) rx_q.push_back(rx_data);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One SPI clock: rise with new MOSI, sample MISO just before the fall.
  task automatic spi_pair(input logic mosi_b, output logic [1:0] pr);
    spi_clock = 1'b1;
    spi_mosi  = mosi_b;
    cycles(8);
    pr = {spi_miso0, spi_miso1};
    spi_clock = 1'b0;
    cycles(8);
  endtask

  task automatic read_pairs(input int n, output logic [63:0] w);
    logic [1:0] pr;
    w = '0;
    for (int i = 0; i < n; i++) begin
      spi_pair(1'b0, pr);
      w = {w[61:0], pr};
    end
  endtask

  task automatic push_word(input logic [63:0] d);
    hit_data  = d;
    hit_valid = 1'b1;
    cycles(1);
    hit_valid = 1'b0;
  endtask

  task automatic csb_low;
    spi_csb = 1'b0;
    cycles(4);
  endtask

  task automatic csb_high;
    spi_csb = 1'b1;
    cycles(6);
  endtask

  initial begin
    logic [63:0] w;
    logic [63:0] d [5];
    logic [1:0]  pr;
    logic [7:0]  b0, b1;
    int          acc;
    int          base;

    reset = 1'b1; spi_csb = 1'b1; spi_clock = 1'b0; spi_mosi = 1'b0;
    hit_data = '0; hit_valid = 1'b0;
    cycles(3);
    check("rst_miso0", spi_miso0, 0);
    check("rst_miso1", spi_miso1, 0);
    check("rst_intb", interruptB, 1);
    check("rst_ready", hit_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_words_sent", words_sent, 0);
    check("rst_aborted", word_aborted, 0);
    reset = 1'b0;
    cycles(3);

    // Single word round trip
    push_word(64'hA5A5_0000_FFFF_1234);
    cycles(1);
    check("intb_after_push", interruptB, 0);
    csb_low();
    read_pairs(32, w);
    check("word1_data", w, 64'hA5A5_0000_FFFF_1234);
    cycles(2);
    check("word1_sent", words_sent, 1);
    check("word1_intb", interruptB, 1);
    csb_high();

    // Empty buffer returns zeros
    csb_low();
    read_pairs(32, w);
    check("empty_data", w, 64'd0);
    check("empty_sent", words_sent, 1);
    check("empty_intb", interruptB, 1);
    csb_high();
    check("empty_no_abort", word_aborted, 0);

    // Overfill a depth-4 buffer
    d[0] = 64'h1111_2222_3333_4444;
    d[1] = 64'h8000_0000_0000_0001;
    d[2] = 64'hDEAD_BEEF_0123_4567;
    d[3] = 64'hFFFF_FFFF_FFFF_FFFE;
    d[4] = 64'h5555_5555_5555_5555;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      hit_data  = d[i];
      hit_valid = 1'b1;
      if (hit_ready) acc++;
      cycles(1);
    end
    hit_valid = 1'b0;
    check("fill_accepted", acc, 4);
    check("fill_ready_low", hit_ready, 0);
    for (int i = 0; i < 4; i++) begin
      csb_low();
      read_pairs(32, w);
      check($sformatf("fill_word%0d", i), w, d[i]);
      if (i == 0) check("ready_after_pop", hit_ready, 1);
      csb_high();
    end
    check("fill_sent", words_sent, 5);

    // MOSI receive path
    b0 = 8'h3C;
    b1 = 8'h81;
    base = rx_q.size();
    csb_low();
    for (int i = 0; i < 8; i++) spi_pair(b0[7-i], pr);
    for (int i = 0; i < 8; i++) spi_pair(b1[7-i], pr);
    check("rx_two_pulses", rx_q.size() - base, 2);
    if (rx_q.size() >= base + 2) begin
      check("rx_byte0", rx_q[base], 8'h3C);
      check("rx_byte1", rx_q[base+1], 8'h81);
    end
    for (int i = 0; i < 4; i++) spi_pair(1'b1, pr);
    csb_high();
    cycles(14);
    check("rx_partial_dropped", rx_q.size() - base, 2);

    // Abort mid-word, then the next word from pair 0
    push_word(64'hCAFE_F00D_1357_9BDF);
    push_word(64'h0F0F_A0A0_3C3C_C3C3);
    csb_low();
    read_pairs(10, w);
    check("abort_partial", w[19:0], 20'hCAFEF);
    csb_high();
    check("abort_flag", word_aborted, 1);
    check("abort_sent", words_sent, 5);
    check("abort_intb", interruptB, 0);
    csb_low();
    read_pairs(32, w);
    check("after_abort_word", w, 64'h0F0F_A0A0_3C3C_C3C3);
    csb_high();
    check("after_abort_sent", words_sent, 6);

    // Reset during pair 21
    push_word(64'hFFFF_FFFF_FFFF_FFFF);
    push_word(64'h0123_4567_89AB_CDEF);
    csb_low();
    read_pairs(20, w);
    spi_clock = 1'b1;
    cycles(4);
    check("pre_reset_miso0", spi_miso0, 1);
    check("pre_reset_intb", interruptB, 0);
    reset = 1'b1;
    #1;
    check("mid_reset_miso0", spi_miso0, 0);
    check("mid_reset_miso1", spi_miso1, 0);
    check("mid_reset_intb", interruptB, 1);
    check("mid_reset_ready", hit_ready, 1);
    check("mid_reset_sent", words_sent, 0);
    check("mid_reset_aborted", word_aborted, 0);
    spi_clock = 1'b0;
    spi_csb   = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(6);
    check("post_reset_intb", interruptB, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
